// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared definitions for the 65C02 register-file arbiter
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

    localparam logic [3:0] c_IDX_X    = 4'h0;
    localparam logic [3:0] c_IDX_Y    = 4'h1;
    localparam logic [3:0] c_IDX_A    = 4'h2;
    localparam logic [3:0] c_IDX_S    = 4'h3;
    localparam logic [3:0] c_IDX_INC  = 4'h5;
    localparam logic [3:0] c_IDX_DEC  = 4'h6;
    localparam logic [3:0] c_IDX_ZERO = 4'h7;
    localparam logic [3:0] c_IDX_NMI  = 4'h8;
    localparam logic [3:0] c_IDX_RST  = 4'h9;
    localparam logic [3:0] c_IDX_BRK  = 4'hA;

    localparam int c_OP_WE      = 6;
    localparam int c_OP_WIDX_HI = 5;
    localparam int c_OP_WIDX_LO = 4;
    localparam int c_OP_RIDX_HI = 3;
    localparam int c_OP_RIDX_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Debug ops use one index for both the write slot and the read port.
    function automatic logic [6:0] dbg_op(input logic we, input logic [3:0] idx);
        logic [6:0] op;
        op = '0;
        op[c_OP_WE]                       = we;
        op[c_OP_WIDX_HI:c_OP_WIDX_LO]     = idx[1:0];
        op[c_OP_RIDX_HI:c_OP_RIDX_LO]     = idx;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_arb.sv
`default_nettype none
// ============================================================================
// regfile_arb : shares the register file between microcode and a debug port
// Revision    : 1.0
// ============================================================================
module regfile_arb
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] core_op,
    input  logic [7:0] core_di,
    input  logic       core_use,
    output logic       core_hold,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [3:0] dbg_idx,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic       dbg_err,
    output logic [7:0] dbg_rdata,
    output logic [6:0] rf_op,
    output logic [7:0] rf_di,
    input  logic [7:0] rf_do
);

    localparam int                 c_CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_MAX);

    arb_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic [3:0]         r_idx;
    logic [7:0]         r_wdata;
    logic               r_err;
    logic [7:0]         r_rdata;

    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_access;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_access  = (r_state == HOLD) || ((r_state == PEND) && !core_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dbg_req) begin
                        r_we    <= dbg_we;
                        r_idx   <= dbg_idx;
                        r_wdata <= dbg_wdata;
                        r_cnt   <= '0;
                        // Only X/Y/A/S are writable; constants are read-only.
                        if (dbg_we && (dbg_idx[3:2] != 2'b00)) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (!core_use) begin
                        if (!r_we) r_rdata <= rf_do;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_CNT_MAX) r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!r_we) r_rdata <= rf_do;
                    r_state <= DONE;
                end
                DONE: begin
                    if (!dbg_req) begin
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_hold = (r_state == HOLD);
    assign dbg_ack   = (r_state == DONE);
    assign dbg_err   = r_err;
    assign dbg_rdata = r_rdata;

    always_comb begin
        rf_op = core_op;
        rf_di = core_di;
        if (w_access) begin
            rf_op = dbg_op(r_we, r_idx);
            rf_di = r_wdata;
        end
    end

endmodule
`default_nettype wire
